// File: rtl/ibuf_fifo.sv
// Router input buffer: DEPTH-entry FIFO of {route mask, payload}. The head entry
// multicasts requests to every routed direction and pops once all are served.
`ifndef PKT_W
`define PKT_W 32
`endif

module ibuf_fifo #(
    parameter int PYLD_W  = `PKT_W,
    parameter int NUM_DIR = 7,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ibuf_vld,
    output logic               ibuf_rdy,
    input  logic [NUM_DIR-1:0] route_req,
    input  logic [PYLD_W-1:0]  payload_i,
    output logic [NUM_DIR-1:0] arb_req,
    input  logic [NUM_DIR-1:0] arb_gnt,
    input  logic [NUM_DIR-1:0] obuf_rdy,
    output logic [PYLD_W-1:0]  payload_o,
    output logic [CNT_W-1:0]   occupancy,
    output logic               drop_pls
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_DIR-1:0] route_mem [DEPTH];
    logic [PYLD_W-1:0]  pyld_mem  [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [NUM_DIR-1:0] head_pend;
    logic [NUM_DIR-1:0] clr;
    logic [NUM_DIR-1:0] pend_nxt;
    logic               head_vld;
    logic               push;
    logic               pop;

    always_comb begin
        head_vld   = (occupancy != '0);
        ibuf_rdy   = (occupancy != CNT_W'(DEPTH));
        push       = ibuf_vld & ibuf_rdy;
        clr        = arb_gnt & obuf_rdy & head_pend;
        pend_nxt   = head_pend & ~clr;
        pop        = head_vld & (pend_nxt == '0);
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
        arb_req    = head_pend;
        payload_o  = head_vld ? pyld_mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            route_mem[wr_ptr] <= route_req;
            pyld_mem[wr_ptr]  <= payload_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            head_pend <= '0;
            drop_pls  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr_nxt;

            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase

            drop_pls <= pop && (route_mem[rd_ptr] == '0);

            // With a single stored entry the next head is the flit being pushed this
            // cycle, which is not yet in the memory, so take it straight from the input.
            if (pop) begin
                if (occupancy > CNT_W'(1))
                    head_pend <= route_mem[rd_ptr_nxt];
                else if (push)
                    head_pend <= route_req;
                else
                    head_pend <= '0;
            end else if (!head_vld) begin
                head_pend <= push ? route_req : '0;
            end else begin
                head_pend <= pend_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ibuf_fifo.sv
// Directed self-checking bench for ibuf_fifo: unicast, multicast, backpressure,
// fill/drain, wrap with zero-route drop, and mid-operation reset.
module tb_ibuf_fifo;

    localparam int PW = 32;
    localparam int ND = 7;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ibuf_vld;
    logic          ibuf_rdy;
    logic [ND-1:0] route_req;
    logic [PW-1:0] payload_i;
    logic [ND-1:0] arb_req;
    logic [ND-1:0] arb_gnt;
    logic [ND-1:0] obuf_rdy;
    logic [PW-1:0] payload_o;
    logic [CW-1:0] occupancy;
    logic          drop_pls;

    int n_cmp  = 0;
    int n_fail = 0;

    ibuf_fifo #(.PYLD_W(PW), .NUM_DIR(ND), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ibuf_vld  (ibuf_vld),
        .ibuf_rdy  (ibuf_rdy),
        .route_req (route_req),
        .payload_i (payload_i),
        .arb_req   (arb_req),
        .arb_gnt   (arb_gnt),
        .obuf_rdy  (obuf_rdy),
        .payload_o (payload_o),
        .occupancy (occupancy),
        .drop_pls  (drop_pls)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ibuf_vld  = 1'b0;
        route_req = '0;
        payload_i = '0;
        arb_gnt   = '0;
        obuf_rdy  = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (arb_req !== 7'h00) begin n_fail++; $display("FAIL rst_arb_req got=%h exp=00", arb_req); end
        n_cmp++; if (ibuf_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_ibuf_rdy got=%b exp=1", ibuf_rdy); end
        n_cmp++; if (payload_o !== 32'h0) begin n_fail++; $display("FAIL rst_payload got=%h exp=0", payload_o); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (drop_pls !== 1'b0) begin n_fail++; $display("FAIL rst_drop got=%b exp=0", drop_pls); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_unicast();
        ibuf_vld = 1'b1; route_req = 7'b0000001; payload_i = 32'hA5A5_0001;
        step();
        idle();
        n_cmp++; if (arb_req !== 7'b0000001) begin n_fail++; $display("FAIL uni_req got=%b exp=0000001", arb_req); end
        n_cmp++; if (payload_o !== 32'hA5A5_0001) begin n_fail++; $display("FAIL uni_payload got=%h exp=a5a50001", payload_o); end
        n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL uni_occ got=%0d exp=1", occupancy); end
        arb_gnt = 7'b0000001; obuf_rdy = 7'b1111111;
        step();
        idle();
        n_cmp++; if (arb_req !== 7'b0000000) begin n_fail++; $display("FAIL uni_req_done got=%b exp=0", arb_req); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL uni_occ_done got=%0d exp=0", occupancy); end
        n_cmp++; if (drop_pls !== 1'b0) begin n_fail++; $display("FAIL uni_drop got=%b exp=0", drop_pls); end
    endtask

    task automatic test_multicast();
        ibuf_vld = 1'b1; route_req = 7'b0000101; payload_i = 32'hB0B0_0002;
        step();
        idle();
        n_cmp++; if (arb_req !== 7'b0000101) begin n_fail++; $display("FAIL mc_req got=%b exp=0000101", arb_req); end
        arb_gnt = 7'b0000001; obuf_rdy = 7'b0000001;
        step();
        idle();
        n_cmp++; if (arb_req !== 7'b0000100) begin n_fail++; $display("FAIL mc_partial got=%b exp=0000100", arb_req); end
        n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL mc_occ got=%0d exp=1", occupancy); end
        n_cmp++; if (payload_o !== 32'hB0B0_0002) begin n_fail++; $display("FAIL mc_payload got=%h exp=b0b00002", payload_o); end
    endtask

    // Continues from multicast: bit 2 still pending.
    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            arb_gnt = 7'b0000100; obuf_rdy = 7'b0000000;
            step();
            n_cmp++; if (arb_req !== 7'b0000100) begin n_fail++; $display("FAIL bp_req[%0d] got=%b exp=0000100", i, arb_req); end
            n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL bp_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        arb_gnt = 7'b0000011; obuf_rdy = 7'b1111111;
        step();
        n_cmp++; if (arb_req !== 7'b0000100) begin n_fail++; $display("FAIL bp_nonpend got=%b exp=0000100", arb_req); end
        arb_gnt = 7'b0000100; obuf_rdy = 7'b0000100;
        step();
        idle();
        n_cmp++; if (arb_req !== 7'b0000000) begin n_fail++; $display("FAIL bp_pop_req got=%b exp=0", arb_req); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL bp_pop_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_fill_drain();
        logic [ND-1:0] rt [4];
        rt[0] = 7'b0000001; rt[1] = 7'b0000010; rt[2] = 7'b0000100; rt[3] = 7'b0001000;
        for (int i = 0; i < 4; i++) begin
            ibuf_vld = 1'b1; route_req = rt[i]; payload_i = 32'h10 + i;
            step();
        end
        n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
        n_cmp++; if (ibuf_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_rdy got=%b exp=0", ibuf_rdy); end
        n_cmp++; if (arb_req !== 7'b0000001) begin n_fail++; $display("FAIL fill_head got=%b exp=0000001", arb_req); end
        n_cmp++; if (payload_o !== 32'h10) begin n_fail++; $display("FAIL fill_payload got=%h exp=10", payload_o); end
        ibuf_vld = 1'b1; route_req = 7'b1000000; payload_i = 32'h99;
        step();
        n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL full_reject_occ got=%0d exp=4", occupancy); end
        // Full and popping in the same cycle: the pending vld must still be refused.
        arb_gnt = 7'b1111111; obuf_rdy = 7'b1111111;
        step();
        idle();
        n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL pop1_occ got=%0d exp=3", occupancy); end
        n_cmp++; if (ibuf_rdy !== 1'b1) begin n_fail++; $display("FAIL pop1_rdy got=%b exp=1", ibuf_rdy); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (arb_req !== rt[i]) begin n_fail++; $display("FAIL drain_req[%0d] got=%b exp=%b", i, arb_req, rt[i]); end
            n_cmp++; if (payload_o !== 32'h10 + i) begin n_fail++; $display("FAIL drain_payload[%0d] got=%h exp=%h", i, payload_o, 32'h10 + i); end
            n_cmp++; if (occupancy !== CW'(4 - i)) begin n_fail++; $display("FAIL drain_occ[%0d] got=%0d exp=%0d", i, occupancy, 4 - i); end
            arb_gnt = 7'b1111111; obuf_rdy = 7'b1111111;
            step();
            idle();
        end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_empty got=%0d exp=0", occupancy); end
        n_cmp++; if (arb_req !== 7'b0000000) begin n_fail++; $display("FAIL drain_req_empty got=%b exp=0", arb_req); end
    endtask

    task automatic test_wrap_zero();
        logic [ND-1:0] rt [9];
        rt[0] = 7'h01; rt[1] = 7'h03; rt[2] = 7'h40; rt[3] = 7'h12; rt[4] = 7'h00;
        rt[5] = 7'h08; rt[6] = 7'h7F; rt[7] = 7'h20; rt[8] = 7'h04;
        for (int i = 0; i < 9; i++) begin
            ibuf_vld = 1'b1; route_req = rt[i]; payload_i = 32'hC000 + i;
            arb_gnt = 7'b1111111; obuf_rdy = 7'b1111111;
            step();
            n_cmp++; if (arb_req !== rt[i]) begin n_fail++; $display("FAIL wrap_req[%0d] got=%b exp=%b", i, arb_req, rt[i]); end
            n_cmp++; if (payload_o !== 32'hC000 + i) begin n_fail++; $display("FAIL wrap_payload[%0d] got=%h exp=%h", i, payload_o, 32'hC000 + i); end
            n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL wrap_occ[%0d] got=%0d exp=1", i, occupancy); end
            n_cmp++; if (drop_pls !== (i == 5)) begin n_fail++; $display("FAIL wrap_drop[%0d] got=%b exp=%b", i, drop_pls, i == 5); end
        end
        idle();
        arb_gnt = 7'b1111111; obuf_rdy = 7'b1111111;
        step();
        idle();
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL wrap_end_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (arb_req !== 7'b0000000) begin n_fail++; $display("FAIL wrap_end_req got=%b exp=0", arb_req); end
        n_cmp++; if (drop_pls !== 1'b0) begin n_fail++; $display("FAIL wrap_end_drop got=%b exp=0", drop_pls); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            ibuf_vld = 1'b1; route_req = 7'b0000001 << i; payload_i = 32'hD0 + i;
            step();
        end
        idle();
        n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL mid_occ_pre got=%0d exp=3", occupancy); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL mid_rst_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (arb_req !== 7'b0000000) begin n_fail++; $display("FAIL mid_rst_req got=%b exp=0", arb_req); end
        n_cmp++; if (payload_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_payload got=%h exp=0", payload_o); end
        n_cmp++; if (ibuf_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rdy got=%b exp=1", ibuf_rdy); end
        #2;
        rst_n = 1'b1;
        ibuf_vld = 1'b1; route_req = 7'b0000001; payload_i = 32'hE0E0;
        step();
        idle();
        n_cmp++; if (arb_req !== 7'b0000001) begin n_fail++; $display("FAIL post_rst_req got=%b exp=0000001", arb_req); end
        n_cmp++; if (payload_o !== 32'hE0E0) begin n_fail++; $display("FAIL post_rst_payload got=%h exp=e0e0", payload_o); end
        n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL post_rst_occ got=%0d exp=1", occupancy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unicast();
        test_multicast();
        test_backpressure();
        test_fill_drain();
        test_wrap_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
